// File: rtl/mem_ops_defs.sv
// rtl/mem_ops_defs.sv - op/state encodings and byte-lane helpers for the data-memory access sequencer
package mem_ops_defs;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_SB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_LHU = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } memState_t;

  function automatic logic isStoreOp(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Anything that is not a byte or halfword op is handled as a word op.
  function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] lo);
    logic r;
    case (op)
      OP_LB, OP_LBU, OP_SB: r = 1'b0;
      OP_LH, OP_LHU, OP_SH: r = lo[0];
      default:              r = (lo != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byteEnable(input logic [2:0] op, input logic [1:0] lo);
    logic [3:0] r;
    case (op)
      OP_LB, OP_LBU, OP_SB: r = 4'b0001 << lo;
      OP_LH, OP_LHU, OP_SH: r = lo[1] ? BE_HI_HALF : BE_LO_HALF;
      default:              r = BE_ALL;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] storeData(input logic [2:0] op, input logic [31:0] wdata);
    logic [31:0] r;
    case (op)
      OP_SB:   r = {4{wdata[7:0]}};
      OP_SH:   r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed byte/half lane of a read word and sign/zero extends it
module load_extend
  import mem_ops_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addrLo,
  input  logic [2:0]  op,
  output logic [31:0] ext
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    case (addrLo)
      2'd0:    laneByte = rdata[7:0];
      2'd1:    laneByte = rdata[15:8];
      2'd2:    laneByte = rdata[23:16];
      default: laneByte = rdata[31:24];
    endcase
    laneHalf = addrLo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (op)
      OP_LB:   ext = {{24{laneByte[7]}}, laneByte};
      OP_LBU:  ext = {24'd0, laneByte};
      OP_LH:   ext = {{16{laneHalf[15]}}, laneHalf};
      OP_LHU:  ext = {16'd0, laneHalf};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequences MEM-stage loads/stores over a req/ack data-memory handshake
module mem_access_ctrl
  import mem_ops_defs::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load,
  output logic              err_align,
  output logic              err_timeout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  memState_t         state, nextState;
  logic [2:0]        opReg;
  logic [ADDR_W-1:0] addrReg;
  logic [31:0]       wdataReg;
  logic [CNT_W-1:0]  waitCnt;
  logic [31:0]       loadExt;
  logic              accept, misaligned, active, ackSeen, timedOut;

  assign accept     = (state == ST_IDLE) && start;
  assign misaligned = isMisaligned(op, addr[1:0]);
  assign active     = (state != ST_IDLE);
  assign ackSeen    = (state == ST_RESP) && mem_ack;
  // waitCnt counts mem_req cycles already elapsed, REQ included; ack in the last one still wins.
  assign timedOut   = (state == ST_RESP) && !mem_ack && (waitCnt == CNT_LAST);

  load_extend uExtend (
    .rdata (mem_rdata),
    .addrLo(addrReg[1:0]),
    .op    (opReg),
    .ext   (loadExt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (start && !misaligned) nextState = ST_REQ;
      ST_REQ:  nextState = ST_RESP;
      ST_RESP: if (mem_ack || timedOut) nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    stall     = active || accept;
    mem_req   = active;
    mem_we    = active && isStoreOp(opReg);
    mem_be    = active ? byteEnable(opReg, addrReg[1:0]) : BE_NONE;
    mem_addr  = {addrReg[ADDR_W-1:2], 2'b00};
    mem_wdata = storeData(opReg, wdataReg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opReg       <= 3'd0;
      addrReg     <= '0;
      wdataReg    <= 32'd0;
      waitCnt     <= '0;
      done        <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      load        <= 32'd0;
    end else begin
      done        <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      if (accept) begin
        opReg    <= op;
        addrReg  <= addr;
        wdataReg <= wdata;
        waitCnt  <= '0;
        if (misaligned) begin
          done      <= 1'b1;
          err_align <= 1'b1;
          load      <= 32'd0;
        end
      end else if (active) begin
        waitCnt <= waitCnt + CNT_W'(1);
      end
      if (ackSeen) begin
        done <= 1'b1;
        if (!isStoreOp(opReg)) load <= loadExt;
      end else if (timedOut) begin
        done        <= 1'b1;
        err_timeout <= 1'b1;
        load        <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, SB = 3'd3;
  localparam logic [2:0] LBU = 3'd4, LHU = 3'd5, SH = 3'd6, SW = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall, done, err_align, err_timeout;
  logic [31:0] load;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  mem_access_ctrl #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .load(load), .err_align(err_align), .err_timeout(err_timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic        chkW;
    logic [31:0] wdata;
  } memExp_t;

  typedef struct {
    logic [31:0] load;
    logic        errA;
    logic        errT;
    int          lat;
    int          reqN;
  } respExp_t;

  memExp_t  memQ[$];
  respExp_t respQ[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int startCyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: request side checked every mem_req cycle, result side on each done pulse.
  int      stallCnt = 0;
  int      reqCnt = 0;
  logic    prevReq = 1'b0;
  logic    haveCur = 1'b0;
  memExp_t curMem;

  always @(negedge clk) begin
    if (reset) begin
      stallCnt = 0;
      reqCnt = 0;
      prevReq = 1'b0;
      haveCur = 1'b0;
    end else begin
      if (stall) stallCnt++;
      if (mem_req) begin
        reqCnt++;
        if (!prevReq) begin
          if (memQ.size() == 0) begin
            check("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
            haveCur = 1'b0;
          end else begin
            curMem = memQ.pop_front();
            haveCur = 1'b1;
          end
        end
        if (haveCur) begin
          check("mem_we", {31'd0, mem_we}, {31'd0, curMem.we});
          check("mem_be", {28'd0, mem_be}, {28'd0, curMem.be});
          check("mem_addr", mem_addr, curMem.addr);
          if (curMem.chkW) check("mem_wdata", mem_wdata, curMem.wdata);
        end
      end
      prevReq = mem_req;
      if (done) begin
        if (respQ.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          respExp_t r;
          r = respQ.pop_front();
          check("load", load, r.load);
          check("err_align", {31'd0, err_align}, {31'd0, r.errA});
          check("err_timeout", {31'd0, err_timeout}, {31'd0, r.errT});
          check("done_latency", cyc - startCyc, r.lat);
          check("stall_cycles", stallCnt, r.lat);
          check("req_cycles", reqCnt, r.reqN);
        end
        stallCnt = 0;
        reqCnt = 0;
      end
    end
  end

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  // ackAt = RESP cycle (1-based) carrying mem_ack; 0 = never.
  task automatic access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int ackAt, input logic hasMem,
                        input logic expWe, input logic [3:0] expBe, input logic [31:0] expAddr,
                        input logic chkW, input logic [31:0] expW, input logic [31:0] expLoad,
                        input logic expA, input logic expT, input int expLat, input int expReq);
    if (hasMem) memQ.push_back('{expWe, expBe, expAddr, chkW, expW});
    respQ.push_back('{expLoad, expA, expT, expLat, expReq});
    startCyc = cyc;
    start = 1'b1; op = o; addr = a; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0;
    if (hasMem) begin
      @(posedge clk); #1;
      if (ackAt > 0) begin
        repeat (ackAt - 1) begin @(posedge clk); #1; end
        mem_ack = 1'b1; mem_rdata = rd;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'd0;
      end
    end
    for (int w = 0; w < 40 && respQ.size() != 0; w++) begin @(posedge clk); #1; end
    if (respQ.size() != 0) begin
      check("done_wait_expired", respQ.size(), 32'd0);
      respQ.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_errs", {30'd0, err_align, err_timeout}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we_be", {27'd0, mem_we, mem_be}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_load", load, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    //     op   addr      wdata     rdata     ack mem we be     maddr     chkW wdata    load      eA eT lat req
    access(LB,  32'h03, 32'h0,      32'h80FFFFFF, 1, 1, 0, 4'b1000, 32'h00, 0, 32'h0,      32'hFFFFFF80, 0, 0, 3, 2);
    access(LHU, 32'h12, 32'h0,      32'h9FFF1234, 3, 1, 0, 4'b1100, 32'h10, 0, 32'h0,      32'h00009FFF, 0, 0, 5, 4);
    access(SB,  32'h21, 32'h000000AB, 32'h12345678, 1, 1, 1, 4'b0010, 32'h20, 1, 32'hABABABAB, 32'h00009FFF, 0, 0, 3, 2);
    access(LW,  32'h06, 32'h0,      32'h0,        0, 0, 0, 4'b0000, 32'h00, 0, 32'h0,      32'h00000000, 1, 0, 1, 0);
    access(LB,  32'h01, 32'h0,      32'h00007F00, 2, 1, 0, 4'b0010, 32'h00, 0, 32'h0,      32'h0000007F, 0, 0, 4, 3);
    access(LH,  32'h02, 32'h0,      32'h8001AAAA, 1, 1, 0, 4'b1100, 32'h00, 0, 32'h0,      32'hFFFF8001, 0, 0, 3, 2);
    access(LBU, 32'h02, 32'h0,      32'h00F00000, 1, 1, 0, 4'b0100, 32'h00, 0, 32'h0,      32'h000000F0, 0, 0, 3, 2);
    access(SH,  32'h06, 32'h1234BEEF, 32'h0,      2, 1, 1, 4'b1100, 32'h04, 1, 32'hBEEFBEEF, 32'h000000F0, 0, 0, 4, 3);
    access(LH,  32'h05, 32'h0,      32'h0,        0, 0, 0, 4'b0000, 32'h00, 0, 32'h0,      32'h00000000, 1, 0, 1, 0);
    access(SH,  32'h03, 32'h5555,   32'h0,        0, 0, 1, 4'b0000, 32'h00, 0, 32'h0,      32'h00000000, 1, 0, 1, 0);
    access(LW,  32'h0C, 32'h0,      32'h13579BDF, 15, 1, 0, 4'b1111, 32'h0C, 0, 32'h0,     32'h13579BDF, 0, 0, 17, 16);
    access(LW,  32'h100, 32'h0,     32'h0,        0, 1, 0, 4'b1111, 32'h100, 0, 32'h0,     32'h00000000, 0, 1, 17, 16);

    // A mem_ack arriving after the timeout must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("late_ack_load", load, 32'd0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;

    // Reset while waiting in RESP.
    check("pre_abort_load", load, 32'd0);
    access(LBU, 32'h00, 32'h0, 32'h000000C3, 1, 1, 0, 4'b0001, 32'h00, 0, 32'h0, 32'h000000C3, 0, 0, 3, 2);
    memQ.push_back('{1'b0, 4'b1111, 32'h10, 1'b0, 32'h0});
    start = 1'b1; op = LW; addr = 32'h10;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; addr = 32'd0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_load", load, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) begin @(posedge clk); #1; end

    access(SW, 32'h40, 32'hDEADBEEF, 32'h0, 2, 1, 1, 4'b1111, 32'h40, 1, 32'hDEADBEEF, 32'h00000000, 0, 0, 4, 3);

    repeat (3) begin @(posedge clk); #1; end
    check("mem_queue_drained", memQ.size(), 32'd0);
    check("resp_queue_drained", respQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
